// File: rtl/tm_queue_depth.sv
// rtl/tm_queue_depth.sv - per-queue depth table with init sweep, enq/deq update pipeline and 2-cycle lookup
`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 4
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tm_queue_depth #(
  parameter int QID_NBITS   = `FIRST_LVL_QUEUE_ID_NBITS,
  parameter int DEPTH_NBITS = `FIRST_LVL_QUEUE_ID_NBITS
) (
  input  logic                   clk,
  input  logic                   `RESET_SIG,
  input  logic                   enq_req,
  input  logic [QID_NBITS-1:0]   enq_qid,
  input  logic                   deq_req,
  input  logic [QID_NBITS-1:0]   deq_qid,
  input  logic                   queue_depth_req,
  input  logic [QID_NBITS-1:0]   queue_id,
  output logic                   queue_depth_ack,
  output logic [DEPTH_NBITS-1:0] queue_depth,
  output logic                   init_done,
  output logic                   depth_err
);

  localparam int NQ = 1 << QID_NBITS;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q;
  logic [QID_NBITS-1:0]   idx_q;
  logic [DEPTH_NBITS-1:0] mem_q [NQ];

  logic                   s1_enq_v_q, s1_deq_v_q, s1_lk_v_q, s1_lk_init_q;
  logic [QID_NBITS-1:0]   s1_enq_qid_q, s1_deq_qid_q, s1_lk_qid_q;
  logic [DEPTH_NBITS-1:0] rd_enq_q, rd_deq_q, rd_lk_q;

  logic                   lw0_v_q, lw1_v_q;
  logic [QID_NBITS-1:0]   lw0_a_q, lw1_a_q;
  logic [DEPTH_NBITS-1:0] lw0_d_q, lw1_d_q;

  logic                   ack_q, err_q, init_done_q;
  logic [DEPTH_NBITS-1:0] depth_q;

  logic [DEPTH_NBITS-1:0] enq_cur_d, deq_cur_d, lk_cur_d;
  logic [DEPTH_NBITS-1:0] wr0_data_d, wr1_data_d, depth_d;
  logic                   wr0_v_d, wr1_v_d, err_d;

  // The memory read launched last cycle misses the write committed on that same edge.
  function automatic logic [DEPTH_NBITS-1:0] fwd(input logic [QID_NBITS-1:0]   a,
                                                 input logic [DEPTH_NBITS-1:0] rd);
    if (lw0_v_q && lw0_a_q == a) return lw0_d_q;
    if (lw1_v_q && lw1_a_q == a) return lw1_d_q;
    return rd;
  endfunction

  always_comb begin
    enq_cur_d  = fwd(s1_enq_qid_q, rd_enq_q);
    deq_cur_d  = fwd(s1_deq_qid_q, rd_deq_q);
    lk_cur_d   = fwd(s1_lk_qid_q, rd_lk_q);
    wr0_data_d = enq_cur_d + 1'b1;
    wr1_data_d = deq_cur_d - 1'b1;
    wr0_v_d    = 1'b0;
    wr1_v_d    = 1'b0;
    err_d      = 1'b0;
    depth_d    = s1_lk_init_q ? '0 : lk_cur_d;
    if (!(s1_enq_v_q && s1_deq_v_q && s1_enq_qid_q == s1_deq_qid_q)) begin
      if (s1_enq_v_q) begin
        if (enq_cur_d == '1) err_d = 1'b1;
        else                 wr0_v_d = 1'b1;
      end
      if (s1_deq_v_q) begin
        if (deq_cur_d == '0) err_d = 1'b1;
        else                 wr1_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_enq_q <= mem_q[enq_qid];
    rd_deq_q <= mem_q[deq_qid];
    rd_lk_q  <= mem_q[queue_id];
    if (state_q == ST_INIT) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wr0_v_d) mem_q[s1_enq_qid_q] <= wr0_data_d;
      if (wr1_v_d) mem_q[s1_deq_qid_q] <= wr1_data_d;
    end
  end

  always_ff @(posedge clk or posedge `RESET_SIG) begin
    if (`RESET_SIG) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      s1_enq_v_q   <= 1'b0;
      s1_deq_v_q   <= 1'b0;
      s1_lk_v_q    <= 1'b0;
      s1_lk_init_q <= 1'b0;
      s1_enq_qid_q <= '0;
      s1_deq_qid_q <= '0;
      s1_lk_qid_q  <= '0;
      lw0_v_q      <= 1'b0;
      lw1_v_q      <= 1'b0;
      lw0_a_q      <= '0;
      lw1_a_q      <= '0;
      lw0_d_q      <= '0;
      lw1_d_q      <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      depth_q      <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
      s1_enq_v_q   <= enq_req && (state_q == ST_RUN);
      s1_deq_v_q   <= deq_req && (state_q == ST_RUN);
      s1_enq_qid_q <= enq_qid;
      s1_deq_qid_q <= deq_qid;
      s1_lk_v_q    <= queue_depth_req;
      s1_lk_init_q <= (state_q == ST_INIT);
      s1_lk_qid_q  <= queue_id;
      lw0_v_q      <= wr0_v_d;
      lw0_a_q      <= s1_enq_qid_q;
      lw0_d_q      <= wr0_data_d;
      lw1_v_q      <= wr1_v_d;
      lw1_a_q      <= s1_deq_qid_q;
      lw1_d_q      <= wr1_data_d;
      ack_q        <= s1_lk_v_q;
      err_q        <= err_d;
      if (s1_lk_v_q) depth_q <= depth_d;
    end
  end

  assign queue_depth_ack = ack_q;
  assign queue_depth     = depth_q;
  assign init_done       = init_done_q;
  assign depth_err       = err_q;

endmodule

// File: tb/tb_tm_queue_depth.sv
// tb/tb_tm_queue_depth.sv - directed bench for tm_queue_depth with a lookup/error scoreboard
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_tm_queue_depth;
  localparam int NQ = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enq_req = 1'b0, deq_req = 1'b0, queue_depth_req = 1'b0;
  logic [3:0] enq_qid = '0, deq_qid = '0, queue_id = '0;
  logic       queue_depth_ack, init_done, depth_err;
  logic [3:0] queue_depth;

  typedef struct { int due; int val; } exp_t;
  exp_t lkq[$];
  int   errq[$];
  int   model[NQ];
  int   pc = 0;
  int   total = 0;
  int   bad = 0;

  tm_queue_depth #(.QID_NBITS(4), .DEPTH_NBITS(4)) dut (
    .clk(clk), .`RESET_SIG(rst),
    .enq_req(enq_req), .enq_qid(enq_qid),
    .deq_req(deq_req), .deq_qid(deq_qid),
    .queue_depth_req(queue_depth_req), .queue_id(queue_id),
    .queue_depth_ack(queue_depth_ack), .queue_depth(queue_depth),
    .init_done(init_done), .depth_err(depth_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    logic ea, ee;
    ea = (lkq.size() > 0) && (lkq[0].due == pc);
    chk("ack", queue_depth_ack, ea);
    if (ea) begin
      e = lkq.pop_front();
      chk("depth", queue_depth, e.val);
    end
    ee = (errq.size() > 0) && (errq[0] == pc);
    if (ee) void'(errq.pop_front());
    chk("depth_err", depth_err, ee);
    chk("init_done", init_done, pc >= 16);
  endtask

  task automatic cyc(input int e, input int eq, input int d, input int dq,
                     input int l, input int lq);
    bit init, err;
    exp_t x;
    @(negedge clk);
    pc++;
    check_outputs();
    enq_req = (e != 0); enq_qid = 4'(eq);
    deq_req = (d != 0); deq_qid = 4'(dq);
    queue_depth_req = (l != 0); queue_id = 4'(lq);
    init = (pc < 16);
    if (l != 0) begin
      x.due = pc + 2;
      x.val = init ? 0 : model[lq];
      lkq.push_back(x);
    end
    if (!init && !(e != 0 && d != 0 && eq == dq)) begin
      err = 1'b0;
      if (e != 0) begin
        if (model[eq] == 15) err = 1'b1;
        else model[eq]++;
      end
      if (d != 0) begin
        if (model[dq] == 0) err = 1'b1;
        else model[dq]--;
      end
      if (err) errq.push_back(pc + 2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enq_req = 1'b0; deq_req = 1'b0; queue_depth_req = 1'b0;
    #1;
    chk("rst_ack", queue_depth_ack, 1'b0);
    chk("rst_err", depth_err, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    lkq.delete();
    errq.delete();
    for (int q = 0; q < NQ; q++) model[q] = 0;
    repeat (3) @(negedge clk);
    chk("rst_depth", queue_depth, 4'd0);
    chk("rst_ack_hold", queue_depth_ack, 1'b0);
    rst = 1'b0;
    pc = 0;
  endtask

  initial begin
    do_reset();
    // INIT phase with a couple of lookups, then lookup every queue in RUN
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, (i == 2 || i == 15) ? 1 : 0, 5);
    for (int q = 0; q < NQ; q++) cyc(0, 0, 0, 0, 1, q);
    idle(3);
    // five back-to-back enqueues then lookup
    for (int i = 0; i < 5; i++) cyc(1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3);
    idle(3);
    // lookup excludes same-cycle event
    cyc(1, 7, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 1, 7);
    idle(3);
    // saturation at all-ones and at zero
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 1, 1);
    cyc(0, 0, 0, 0, 1, 2);
    idle(3);
    // simultaneous same-qid at 15 and at 0, then different qids
    for (int i = 0; i < 15; i++) cyc(1, 4, 0, 0, 0, 0);
    cyc(1, 4, 1, 4, 0, 0);
    cyc(1, 8, 1, 8, 1, 4);
    cyc(1, 6, 0, 0, 1, 8);
    cyc(1, 5, 1, 6, 0, 0);
    cyc(0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 1, 6);
    cyc(1, 1, 1, 9, 1, 1);
    idle(3);
    // random traffic on a few queues
    for (int i = 0; i < 60; i++)
      cyc($urandom_range(0, 1), $urandom_range(10, 12), $urandom_range(0, 1),
          $urandom_range(10, 12), $urandom_range(0, 1), $urandom_range(10, 12));
    for (int q = 0; q < NQ; q++) cyc(0, 0, 0, 0, 1, q);
    idle(3);
    // pending lookups discarded by reset; INIT ignores updates and re-zeroes table
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 4);
    cyc(0, 0, 0, 0, 1, 7);
    do_reset();
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 1, 1);
    cyc(0, 0, 1, 5, 0, 0);
    idle(14);
    cyc(0, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 4);
    idle(4);
    chk("lookups_drained", lkq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tm_queue_depth.md
TM_QUEUE_DEPTH -- requirements
Module: tm_queue_depth

Interface
REQ-001 SHALL have parameter QID_NBITS, default `FIRST_LVL_QUEUE_ID_NBITS, queue id width; 2^QID_NBITS queues.
REQ-002 SHALL have parameter DEPTH_NBITS, default `FIRST_LVL_QUEUE_ID_NBITS, per-queue depth counter width.
REQ-003 SHALL have clk input 1: sole clock; all state on rising edge.
REQ-004 SHALL have a reset input 1, port named by `RESET_SIG: asynchronous, active-high.
REQ-005 SHALL have enq_req input 1: one packet enqueued to enq_qid this cycle.
REQ-006 SHALL have enq_qid input QID_NBITS: enqueue target queue.
REQ-007 SHALL have deq_req input 1: one packet dequeued from deq_qid this cycle.
REQ-008 SHALL have deq_qid input QID_NBITS: dequeue source queue.
REQ-009 SHALL have queue_depth_req input 1: depth lookup request from the poll stage.
REQ-010 SHALL have queue_id input QID_NBITS: lookup queue id.
REQ-011 SHALL have queue_depth_ack output 1: lookup response valid, one-cycle pulse.
REQ-012 SHALL have queue_depth output DEPTH_NBITS: looked-up depth, valid with queue_depth_ack.
REQ-013 SHALL have init_done output 1: table initialised, updates accepted.
REQ-014 SHALL have depth_err output 1: one-cycle pulse on saturated enqueue or dequeue.

Function
REQ-015 SHALL hold one DEPTH_NBITS counter per queue, stored as synchronous-read memory (1-cycle read latency); reads of entries written in the last two cycles SHALL be resolved by forwarding.
REQ-016 SHALL have FSM states INIT and RUN; reset forces INIT with sweep index 0.
REQ-017 INIT: SHALL write 0 to entry = sweep index each cycle, index 0..2^QID_NBITS-1; after the final write SHALL enter RUN; init_done SHALL be 1 from the first RUN cycle.
REQ-018 INIT: enq_req/deq_req SHALL be ignored (no update, no depth_err).
REQ-019 queue_depth_req SHALL produce exactly one queue_depth_ack 2 cycles later (req at cycle T -> ack at T+2), in any state, back-to-back every cycle, order preserved.
REQ-020 A lookup issued in INIT SHALL return queue_depth=0.
REQ-021 RUN: a lookup at cycle T SHALL return the depth after all enq/deq presented in cycles < T, excluding events presented in cycle T itself.
REQ-022 RUN: updates SHALL equal strict sequential application of every accepted event, including same-qid events on consecutive cycles (no lost updates).
REQ-023 Enqueue only: depth+1; at all-ones, depth SHALL hold all-ones and depth_err SHALL pulse.
REQ-024 Dequeue only: depth-1; at 0, depth SHALL hold 0 and depth_err SHALL pulse.
REQ-025 enq and deq same cycle, same qid: net change 0, no depth_err, including at 0 and all-ones.
REQ-026 enq and deq same cycle, different qids: both updates applied independently, each with its own saturation check; depth_err SHALL pulse if either saturates.
REQ-027 depth_err SHALL assert 2 cycles after the offending event.
REQ-028 Depth arithmetic SHALL be unsigned, DEPTH_NBITS wide; no wrap-around.

Reset
REQ-029 Reset assertion SHALL immediately clear queue_depth_ack, depth_err, init_done and all in-flight pipeline valids; pending lookups are discarded, not answered.
REQ-030 queue_depth SHALL reset to 0; memory contents are not reset directly, only by the INIT sweep.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from index 0 on deassertion.

Verification (QID_NBITS=4, DEPTH_NBITS=4)
REQ-032 Release reset, hold idle -> init_done=0 for 16 cycles then 1; lookup of every qid returns 0.
REQ-033 5 enq to qid 3 on consecutive cycles, lookup qid 3 in the next cycle -> ack 2 cycles later, queue_depth=5.
REQ-034 Lookup qid 7 in the same cycle as enq qid 7 from depth 2 -> returns 2; lookup next cycle -> returns 3.
REQ-035 16 enq to qid 1 -> depth 15, depth_err one pulse on the 16th; deq from qid 2 at depth 0 -> depth stays 0, depth_err pulses.
REQ-036 qid 4 at 15, simultaneous enq+deq qid 4 -> depth 15, no depth_err; enq qid 5 + deq qid 6 (depth 1) -> 1 and 0.
REQ-037 Lookups on 3 consecutive cycles, reset asserted before the acks return -> no ack emitted; INIT restarts; enq during INIT leaves depth 0.
